// File: rtl/shift_led_sequencer_if.sv
// Control/data bundle between the LED sequencer and its requester/shift-register side.
interface shift_led_sequencer_if #(
   parameter int LED_N = 8
);
   logic             man_req;
   logic             man_d;
   logic             pat_load;
   logic [LED_N-1:0] pattern;
   logic             auto_en;
   logic             sr_ce;
   logic             sr_d;
   logic             busy;
   logic             load_done;
   logic             req_drop;

   modport master (
      output man_req, man_d, pat_load, pattern, auto_en,
      input  sr_ce, sr_d, busy, load_done, req_drop
   );

   modport slave (
      input  man_req, man_d, pat_load, pattern, auto_en,
      output sr_ce, sr_d, busy, load_done, req_drop
   );
endinterface

// File: rtl/shift_led_sequencer.sv
// Drives a serial LED shift register: manual shifts, MSB-first pattern loads and
// periodic rotate-left ticks, keeping a shadow copy of the downstream register.
module shift_led_sequencer #(
   parameter int LED_N  = 8,
   parameter int PERIOD = 1000000
) (
   input logic                  clk,
   input logic                  rst,
   shift_led_sequencer_if.slave bus
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int BIT_W = (LED_N > 1) ? $clog2(LED_N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               sr_ce_q, sr_ce_d;
   logic               sr_d_q, sr_d_d;
   logic               busy_q, busy_d;
   logic               load_done_q, load_done_d;
   logic               req_drop_q, req_drop_d;
   logic [LED_N-1:0]   shadow_q, shadow_d;
   logic [LED_N-1:0]   pat_q, pat_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pend_q, pend_d;
   logic [LED_N-1:0]   shadow_nx;
   logic               tick;

   always_comb begin
      state_d     = state_q;
      sr_ce_d     = 1'b0;
      sr_d_d      = 1'b0;
      load_done_d = 1'b0;
      req_drop_d  = 1'b0;
      pat_d       = pat_q;
      bit_cnt_d   = bit_cnt_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      // Register contents after the shift currently on the outputs lands; a tick
      // decided right behind a shift must rotate the post-shift MSB.
      shadow_nx   = sr_ce_q ? {shadow_q[LED_N-2:0], sr_d_q} : shadow_q;
      shadow_d    = shadow_nx;
      tick        = (cnt_q == CNT_W'(PERIOD - 1));

      case (state_q)
         S_IDLE: begin
            if (bus.pat_load) begin
               pat_d      = bus.pattern;
               bit_cnt_d  = '0;
               req_drop_d = bus.man_req;
               state_d    = S_LOAD;
            end else if (bus.man_req) begin
               sr_ce_d = 1'b1;
               sr_d_d  = bus.man_d;
            end else if (bus.auto_en) begin
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = S_RUN;
            end
         end

         S_LOAD: begin
            sr_ce_d    = 1'b1;
            sr_d_d     = pat_q[LED_N-1];
            pat_d      = {pat_q[LED_N-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            req_drop_d = bus.man_req;
            if (bit_cnt_q == BIT_W'(LED_N - 1)) begin
               load_done_d = 1'b1;
               bit_cnt_d   = '0;
               cnt_d       = '0;
               pend_d      = 1'b0;
               state_d     = bus.auto_en ? S_RUN : S_IDLE;
            end
         end

         S_RUN: begin
            if (bus.pat_load) begin
               pat_d      = bus.pattern;
               bit_cnt_d  = '0;
               cnt_d      = '0;
               pend_d     = 1'b0;
               req_drop_d = bus.man_req;
               state_d    = S_LOAD;
            end else if (!bus.auto_en) begin
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = S_IDLE;
               if (bus.man_req) begin
                  sr_ce_d = 1'b1;
                  sr_d_d  = bus.man_d;
               end
            end else begin
               cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
               if (bus.man_req) begin
                  sr_ce_d = 1'b1;
                  sr_d_d  = bus.man_d;
                  if (tick) begin
                     pend_d = 1'b1;
                  end
               end else if (pend_q || tick) begin
                  sr_ce_d = 1'b1;
                  sr_d_d  = shadow_nx[LED_N-1];
                  pend_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sr_ce_q     <= 1'b0;
         sr_d_q      <= 1'b0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
         req_drop_q  <= 1'b0;
         shadow_q    <= '0;
         pat_q       <= '0;
         bit_cnt_q   <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_ce_q     <= sr_ce_d;
         sr_d_q      <= sr_d_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
         req_drop_q  <= req_drop_d;
         shadow_q    <= shadow_d;
         pat_q       <= pat_d;
         bit_cnt_q   <= bit_cnt_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
      end
   end

   assign bus.sr_ce     = sr_ce_q;
   assign bus.sr_d      = sr_d_q;
   assign bus.busy      = busy_q;
   assign bus.load_done = load_done_q;
   assign bus.req_drop  = req_drop_q;

endmodule

// File: doc/shift_led_sequencer.md
SHIFT_LED_SEQUENCER -- requirements
Module: shift_led_sequencer

Interface
REQ-001 Parameter LED_N, default 8, width of the downstream LED shift register and of the pattern.
REQ-002 Parameter PERIOD, default 1000000, clk cycles between auto-rotate steps; legal range 2..2^24.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 man_req  in  1  single-cycle manual shift request (already debounced and edge-detected upstream).
REQ-006 man_d  in  1  data bit for a manual shift, sampled with man_req.
REQ-007 pat_load  in  1  single-cycle request to load the pattern serially.
REQ-008 pattern  in  LED_N  pattern to load, sampled with pat_load.
REQ-009 auto_en  in  1  level; high enables auto-rotate.
REQ-010 sr_ce  out  1  registered shift enable to the shift register.
REQ-011 sr_d  out  1  registered serial data to the shift register.
REQ-012 busy  out  1  high while in LOAD.
REQ-013 load_done  out  1  one-cycle pulse when a serial load completes.
REQ-014 req_drop  out  1  one-cycle pulse when a man_req is discarded.

Function
REQ-015 The downstream register is q <= {q[LED_N-2:0], sr_d} when sr_ce is high; the block keeps a shadow register shadow[LED_N-1:0] updated identically on every sr_ce pulse, so shadow always equals q.
REQ-016 The FSM has three states: IDLE, LOAD and RUN; sr_ce and sr_d are registered, one cycle after the decision cycle.
REQ-017 IDLE: pat_load -> latch pattern, clear bit_cnt, go LOAD; else man_req -> sr_ce=1 and sr_d=man_d in the next cycle, stay IDLE; else auto_en=1 -> go RUN with period counter cleared.
REQ-018 IDLE: pat_load and man_req in the same cycle -> pat_load wins and req_drop pulses.
REQ-019 LOAD: for LED_N consecutive cycles, issue sr_ce=1 with sr_d=latched[LED_N-1-bit_cnt] (MSB first); after the last bit, q equals the pattern.
REQ-020 LOAD: busy=1 throughout; pat_load is ignored; each man_req is discarded with a req_drop pulse.
REQ-021 LOAD end: load_done pulses together with the final sr_ce; the next state is RUN if auto_en=1, else IDLE; the period counter is cleared.
REQ-022 RUN: the period counter counts 0..PERIOD-1 and wraps; on each wrap, issue tick: sr_ce=1, sr_d=shadow[LED_N-1] (rotate left by one).
REQ-023 RUN: man_req -> sr_ce=1 with sr_d=man_d; if it coincides with a tick, the manual shift wins and the tick is issued in the next cycle via a pending flag (max one pending).
REQ-024 RUN: pat_load -> go LOAD; any pending tick is discarded.
REQ-025 RUN: auto_en=0 -> go IDLE; the counter and pending flag are cleared; a man_req in the same cycle is still executed.
REQ-026 sr_ce is never high in two consecutive cycles, except in LOAD and in a deferred tick following a manual shift.
REQ-027 load_done and req_drop are mutually independent single-cycle pulses and default to 0.

Reset
REQ-028 rst=1 at a posedge -> state IDLE; sr_ce=0, sr_d=0, busy=0, load_done=0, req_drop=0, shadow=0, bit_cnt=0, period counter=0, pending=0.
REQ-029 rst mid-LOAD or mid-RUN abandons the operation with no further sr_ce; inputs in the reset cycle are ignored.

Verification
REQ-030 LED_N=8: pat_load with pattern=8'hA5 in IDLE -> 8 cycles sr_ce=1 with sr_d=1,0,1,0,0,1,0,1; load_done on the 8th; model q=8'hA5; busy high for 8 cycles.
REQ-031 PERIOD=4, after loading 8'h81 with auto_en=1 -> sr_ce every 4 cycles; q sequence 8'h03, 8'h06, 8'h0C.
REQ-032 RUN: man_req (man_d=0) in the same cycle as a tick -> manual shift first, tick in the next cycle; the two sr_ce pulses are back-to-back; shadow matches the model.
REQ-033 man_req during LOAD -> req_drop pulses once; the load sequence is unchanged; the final q equals the pattern.
REQ-034 rst asserted at the 3rd LOAD cycle -> the next cycle has sr_ce=0, busy=0, state IDLE; a subsequent man_req (man_d=1) gives q=8'h01 in the model.
